// File: rtl/planar_ham_pkg.sv
// Shared command encodings, HAM control codes and channel expansion for the
// planar bitplane video generator.
package planar_ham_pkg;

    typedef enum logic [1:0] {
        OP_SET_PIX_ADDR = 2'd0,
        OP_WRITE_PIX    = 2'd1,
        OP_SET_PAL_ADDR = 2'd2,
        OP_WRITE_PAL    = 2'd3
    } cmd_op_e;

    localparam logic [1:0] HAM_PAL = 2'b00;
    localparam logic [1:0] HAM_B   = 2'b01;
    localparam logic [1:0] HAM_R   = 2'b10;
    localparam logic [1:0] HAM_G   = 2'b11;

    // Widen a dbits-wide value (right-aligned in d) to 8 bits by repeating its
    // bit pattern from the MSB down, so full scale maps to 0xFF.
    function automatic logic [7:0] ham_expand(input logic [7:0] d, input int dbits);
        int n;
        logic [7:0] e;
        n = (dbits > 8) ? 8 : ((dbits < 1) ? 1 : dbits);
        e = '0;
        for (int k = 0; k < 8; k++) begin
            e[3'(7 - k)] = d[3'(n - 1 - (k % n))];
        end
        return e;
    endfunction

endpackage

// File: rtl/planar_ham_video_plane_bank.sv
// One bitplane: byte-wide synchronous RAM, one write port and one registered
// read port with read-before-write behaviour on address collisions.
module plane_bank #(
    parameter int DEPTH = 6144,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/planar_ham_video.sv
// Planar bitplane framebuffer and pixel generator: PLANES bitplanes, runtime
// HAM/indexed decode, 24-bit palette, auto-incrementing command port.
module planar_ham_video
    import planar_ham_pkg::*;
#(
    parameter int X_BITS      = 10,
    parameter int Y_BITS      = 10,
    parameter int H_OFFSET    = 104,
    parameter int V_OFFSET    = 48,
    parameter int WIDTH       = 256,
    parameter int HEIGHT      = 192,
    parameter int SCALE_SHIFT = 1,
    parameter int PLANES      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_BITS-1:0] x,
    input  logic [Y_BITS-1:0] y,
    input  logic              ham_en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [23:0]       cmd_data,
    output logic [23:0]       rgb
);

    localparam int PB    = WIDTH * HEIGHT / 8;
    localparam int BW    = $clog2(PB);
    localparam int TOT   = PLANES * PB;
    localparam int AW    = $clog2(TOT);
    localparam int D     = PLANES - 2;
    localparam int NPAL  = 1 << PLANES;
    localparam int ACT_W = WIDTH << SCALE_SHIFT;
    localparam int ACT_H = HEIGHT << SCALE_SHIFT;

    logic              rdy_q;
    logic [AW-1:0]     pix_addr;
    logic [PLANES-1:0] pal_addr;
    logic [23:0]       pal0_shadow;
    logic [23:0]       hold;
    logic              ham_line;

    cmd_op_e           op;
    logic              fire;
    logic              pix_wr;
    logic              pal_wr;
    logic [31:0]       pix_addr_w;
    logic [PLANES-1:0] bank_we;
    logic [BW-1:0]     bank_waddr;

    logic [X_BITS-1:0] sx_p0;
    logic [Y_BITS-1:0] sy_p0;
    logic [31:0]       col_p0;
    logic [31:0]       line_p0;
    logic [BW-1:0]     raddr_p0;
    logic              active_p0;
    logic              first_p0;
    logic              mode_p0;

    logic [7:0]        bank_q_p1 [PLANES];
    logic              active_p1;
    logic              first_p1;
    logic              mode_p1;
    logic [2:0]        bitsel_p1;
    logic [PLANES-1:0] pix_p1;
    logic [PLANES-1:0] pal_idx_p1;

    logic [23:0]       palette [0:NPAL-1];
    logic [23:0]       pal_q_p2;
    logic [PLANES-1:0] pix_p2;
    logic              active_p2;
    logic              first_p2;
    logic              mode_p2;
    logic [23:0]       base_p2;
    logic [7:0]        chan_p2;
    logic [23:0]       colour_p2;

    assign cmd_ready  = rdy_q && !rst;
    assign op         = cmd_op_e'(cmd_op);
    assign fire       = cmd_valid && cmd_ready;
    assign pix_wr     = fire && (op == OP_WRITE_PIX);
    assign pal_wr     = fire && (op == OP_WRITE_PAL);
    assign pix_addr_w = 32'(pix_addr);

    // Linear address -> (plane, offset); addresses past the last plane match nothing.
    always_comb begin
        bank_we    = '0;
        bank_waddr = '0;
        for (int i = 0; i < PLANES; i++) begin
            if (pix_wr && pix_addr_w >= 32'(i * PB) && pix_addr_w < 32'((i + 1) * PB)) begin
                bank_we[i] = 1'b1;
                bank_waddr = BW'(pix_addr_w - 32'(i * PB));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            pix_addr    <= '0;
            pal_addr    <= '0;
            pal0_shadow <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (fire) begin
                case (op)
                    OP_SET_PIX_ADDR: pix_addr <= cmd_data[AW-1:0];
                    OP_WRITE_PIX:    pix_addr <= (pix_addr == AW'(TOT - 1)) ? '0 : pix_addr + AW'(1);
                    OP_SET_PAL_ADDR: pal_addr <= cmd_data[PLANES-1:0];
                    default: begin
                        pal_addr <= pal_addr + PLANES'(1);
                        if (pal_addr == '0) begin
                            pal0_shadow <= cmd_data;
                        end
                    end
                endcase
            end
        end
    end

    // Stage 0: raster position -> source address and line-start flag.
    always_comb begin
        sx_p0     = x - X_BITS'(H_OFFSET);
        sy_p0     = y - Y_BITS'(V_OFFSET);
        active_p0 = (32'(sx_p0) < 32'(ACT_W)) && (32'(sy_p0) < 32'(ACT_H));
        first_p0  = active_p0 && (sx_p0 == '0);
        mode_p0   = first_p0 ? ham_en : ham_line;
        col_p0    = 32'(sx_p0) >> SCALE_SHIFT;
        line_p0   = 32'(sy_p0) >> SCALE_SHIFT;
        raddr_p0  = BW'(line_p0 * 32'(WIDTH / 8) + (col_p0 >> 3));
    end

    for (genvar g = 0; g < PLANES; g++) begin : g_bank
        plane_bank #(
            .DEPTH(PB),
            .AW   (BW)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we[g]),
            .waddr(bank_waddr),
            .wdata(cmd_data[7:0]),
            .raddr(raddr_p0),
            .rdata(bank_q_p1[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ham_line  <= 1'b0;
            active_p1 <= 1'b0;
            first_p1  <= 1'b0;
            active_p2 <= 1'b0;
            first_p2  <= 1'b0;
        end else begin
            if (first_p0) begin
                ham_line <= ham_en;
            end
            active_p1 <= active_p0;
            first_p1  <= first_p0;
            active_p2 <= active_p1;
            first_p2  <= first_p1;
        end
    end

    always_ff @(posedge clk) begin
        mode_p1   <= mode_p0;
        bitsel_p1 <= col_p0[2:0];
        mode_p2   <= mode_p1;
        pix_p2    <= pix_p1;
    end

    // Stage 1 -> 2: gather one bit per plane (bit 7 is leftmost), then palette lookup.
    always_comb begin
        pix_p1 = '0;
        for (int i = 0; i < PLANES; i++) begin
            pix_p1[i] = bank_q_p1[i][~bitsel_p1];
        end
        pal_idx_p1 = mode_p1 ? PLANES'(pix_p1[D-1:0]) : pix_p1;
    end

    always_ff @(posedge clk) begin
        if (pal_wr) begin
            palette[pal_addr] <= cmd_data;
        end
        pal_q_p2 <= palette[pal_idx_p1];
    end

    // Stage 2 -> 3: HAM modify against the hold colour, or plain palette colour.
    always_comb begin
        base_p2   = first_p2 ? pal0_shadow : hold;
        chan_p2   = ham_expand(8'(pix_p2[D-1:0]), D);
        colour_p2 = pal_q_p2;
        if (mode_p2) begin
            case (pix_p2[PLANES-1 -: 2])
                HAM_PAL: colour_p2 = pal_q_p2;
                HAM_B:   colour_p2 = {base_p2[23:8], chan_p2};
                HAM_R:   colour_p2 = {chan_p2, base_p2[15:0]};
                default: colour_p2 = {base_p2[23:16], chan_p2, base_p2[7:0]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb  <= '0;
            hold <= '0;
        end else if (!active_p2) begin
            rgb <= '0;
        end else begin
            rgb  <= colour_p2;
            hold <= colour_p2;
        end
    end

endmodule

// File: tb/tb_planar_ham_video.sv
// Directed bench for planar_ham_video: reset, indexed and HAM decode, address
// wrap, active-area boundaries and mid-frame reset.
`timescale 1ns/1ps
module tb_planar_ham_video;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        ham_en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [23:0] cmd_data = '0;
    logic [23:0] rgb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [9:0]  vx;
        logic [9:0]  vy;
        logic [23:0] want;
    } vec_t;

    vec_t        vecs [12];
    logic [23:0] cap [16];
    logic [23:0] ham_want [10] = '{24'h112233, 24'h112233, 24'hAA2233, 24'hAA2233,
                                   24'hAAFF33, 24'hAAFF33, 24'hAAFF55, 24'hAAFF55,
                                   24'h000055, 24'h000055};
    logic [7:0]  ham_line1 [6] = '{8'hB0, 8'h60, 8'h30, 8'h60, 8'h30, 8'h60};

    always #5 clk = ~clk;

    planar_ham_video dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .ham_en   (ham_en),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rgb      (rgb)
    );

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %06h, expected %06h", name, got, want);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [23:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout: got 0, expected 1");
        end
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wpix(input int addr, input logic [7:0] d);
        send(2'd0, 24'(addr));
        send(2'd1, {16'h0000, d});
    endtask

    task automatic wpal(input int idx, input logic [23:0] d);
        send(2'd2, 24'(idx));
        send(2'd3, d);
    endtask

    // Hold a pixel steady for three clocks and compare the output.
    task automatic show(input logic [9:0] px, input logic [9:0] py, input logic h,
                        input string name, input logic [23:0] want);
        @(negedge clk);
        x = px;
        y = py;
        ham_en = h;
        repeat (3) @(negedge clk);
        check(name, rgb, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"idx_x104",        10'd104, 10'd48,  24'h123456};
        vecs[1]  = '{"idx_x105",        10'd105, 10'd48,  24'h123456};
        vecs[2]  = '{"idx_x106_pal0",   10'd106, 10'd48,  24'h0A0B0C};
        vecs[3]  = '{"idx_line_repl",   10'd104, 10'd49,  24'h123456};
        vecs[4]  = '{"wrap_bb_col4",    10'd112, 10'd48,  24'h112233};
        vecs[5]  = '{"wrap_aa_col248",  10'd600, 10'd431, 24'h321032};
        vecs[6]  = '{"x_last_active",   10'd615, 10'd431, 24'h0A0B0C};
        vecs[7]  = '{"x_past_end",      10'd616, 10'd431, 24'h000000};
        vecs[8]  = '{"y_line430",       10'd600, 10'd430, 24'h321032};
        vecs[9]  = '{"y_past_end",      10'd600, 10'd432, 24'h000000};
        vecs[10] = '{"x_underflow",     10'd50,  10'd48,  24'h000000};
        vecs[11] = '{"y_underflow",     10'd104, 10'd40,  24'h000000};

        // Power-on reset for three clocks.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_rgb", rgb, 24'h0);
            check("reset_ready", {23'h0, cmd_ready}, 24'h0);
        end
        rst = 1'b0;
        #1;
        check("ready_first_cycle", {23'h0, cmd_ready}, 24'h0);
        @(negedge clk);
        check("ready_second_cycle", {23'h0, cmd_ready}, 24'h1);
        check("rgb_after_reset", rgb, 24'h0);

        wpal(0, 24'h000000);
        wpal(1, 24'h112233);
        wpal(5, 24'h123456);
        wpal(32, 24'h321032);
        for (int p = 0; p < 6; p++) begin
            wpix(p * 6144, (p == 0 || p == 2) ? 8'h80 : 8'h00);
            wpix(p * 6144 + 32, ham_line1[p]);
            wpix(p * 6144 + 64, (p % 2 == 0) ? 8'h80 : 8'h00);
            if (p < 5) wpix(p * 6144 + 6143, 8'h00);
        end

        // HAM stream on source line 1, ham_en dropped mid-line, then line 2 start.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            cap[k] = rgb;
            if (k < 8) begin
                x = 10'(104 + k);
                y = 10'd50;
                ham_en = (k == 0);
            end else if (k < 10) begin
                x = 10'(104 + k - 8);
                y = 10'd52;
                ham_en = 1'b1;
            end else begin
                x = '0;
                y = '0;
                ham_en = 1'b0;
            end
        end
        for (int k = 0; k < 10; k++) begin
            check($sformatf("ham_px%0d", k), cap[k + 3], ham_want[k]);
        end

        wpal(0, 24'h0A0B0C);
        send(2'd0, 24'd36863);
        send(2'd1, 24'h0000AA);
        send(2'd1, 24'h0000BB);

        for (int i = 0; i < 12; i++) begin
            show(vecs[i].vx, vecs[i].vy, 1'b0, vecs[i].name, vecs[i].want);
        end

        // Palette address wrap: second write lands at index 0 and the shadow.
        send(2'd2, 24'd63);
        send(2'd3, 24'h445566);
        send(2'd3, 24'h778899);
        show(10'd106, 10'd48, 1'b0, "palwrap_idx0", 24'h778899);
        show(10'd108, 10'd50, 1'b0, "palwrap_idx63", 24'h445566);
        show(10'd104, 10'd52, 1'b1, "palwrap_shadow_ham", 24'h778855);

        // Mid-frame reset on a steady active pixel.
        show(10'd104, 10'd48, 1'b0, "pre_reset", 24'h123456);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rgb1", rgb, 24'h0);
        check("midrst_ready1", {23'h0, cmd_ready}, 24'h0);
        @(negedge clk);
        check("midrst_rgb2", rgb, 24'h0);
        rst = 1'b0;
        #1;
        check("midrst_ready_first", {23'h0, cmd_ready}, 24'h0);
        @(negedge clk);
        check("midrst_flush1", rgb, 24'h0);
        check("midrst_ready_second", {23'h0, cmd_ready}, 24'h1);
        @(negedge clk);
        check("midrst_flush2", rgb, 24'h0);
        @(negedge clk);
        check("midrst_resume", rgb, 24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
